// File: rtl/shift_pkg.sv
// Shared opcode and FSM state definitions for the shift register engine.
package shift_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_CLEAR = 3'd2;
  localparam logic [2:0] OP_SHL   = 3'd3;
  localparam logic [2:0] OP_SHR   = 3'd4;
  localparam logic [2:0] OP_ASR   = 3'd5;
  localparam logic [2:0] OP_ROL   = 3'd6;
  localparam logic [2:0] OP_ROR   = 3'd7;

  // Opcodes 3..7 are the multi-step shift/rotate family.
  function automatic logic is_shift_op(logic [2:0] op);
    return op >= OP_SHL;
  endfunction

endpackage

// File: rtl/shift_reg_engine_if.sv
// Command port and status outputs of the shift register engine.
interface shift_reg_engine_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amount;
  logic [WIDTH-1:0] cmd_data;
  logic             serial_in;
  logic             step_en;
  logic [WIDTH-1:0] data_out;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_amount, cmd_data, serial_in, step_en,
    input  cmd_ready, data_out, serial_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amount, cmd_data, serial_in, step_en,
    output cmd_ready, data_out, serial_out, busy, done
  );
endinterface

// File: rtl/shift_step.sv
// Combinational single-step datapath: applies one opcode to the register value.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] data_o,
  output logic             out_bit_o
);

  always_comb begin
    data_o    = data_i;
    out_bit_o = 1'b0;
    unique case (op_i)
      OP_NOP, OP_LOAD: data_o = data_i;
      OP_CLEAR:        data_o = '0;
      OP_SHL: begin
        data_o    = {data_i[WIDTH-2:0], serial_i};
        out_bit_o = data_i[WIDTH-1];
      end
      OP_SHR: begin
        data_o    = {serial_i, data_i[WIDTH-1:1]};
        out_bit_o = data_i[0];
      end
      OP_ASR: begin
        data_o    = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
        out_bit_o = data_i[0];
      end
      OP_ROL: begin
        data_o    = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
        out_bit_o = data_i[WIDTH-1];
      end
      OP_ROR: begin
        data_o    = {data_i[0], data_i[WIDTH-1:1]};
        out_bit_o = data_i[0];
      end
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_reg_engine.sv
// WIDTH-bit load/shift/rotate register driven by a valid/ready command port,
// stepping one bit position per enabled cycle.
module shift_reg_engine
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_reg_engine_if.slave bus
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_in;
  logic [WIDTH-1:0] step_data;
  logic             step_bit;

  // One datapath serves both the accept edge (LOAD/CLEAR) and every SHIFT step.
  assign step_op = (state_q == ST_SHIFT) ? op_q : bus.cmd_op;
  assign step_in = (state_q == ST_IDLE && bus.cmd_op == OP_LOAD) ? bus.cmd_data : data_q;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op_i      (step_op),
    .data_i    (step_in),
    .serial_i  (bus.serial_in),
    .data_o    (step_data),
    .out_bit_o (step_bit)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    data_d  = data_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (!is_shift_op(bus.cmd_op)) begin
            data_d = step_data;
            done_d = 1'b1;
          end else if (bus.cmd_amount == '0) begin
            done_d = 1'b1;
          end else begin
            op_d    = bus.cmd_op;
            rem_d   = bus.cmd_amount;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (bus.step_en) begin
          data_d = step_data;
          sout_d = step_bit;
          rem_d  = rem_q - AMT_W'(1);
          if (rem_q == AMT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      op_q    <= OP_NOP;
      data_q  <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q == ST_SHIFT);
  assign bus.data_out   = data_q;
  assign bus.serial_out = sout_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_shift_reg_engine.sv
// Directed self-checking bench for shift_reg_engine (WIDTH=8, AMT_W=3).
module tb_shift_reg_engine;
  import shift_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  shift_reg_engine_if #(.WIDTH(8), .AMT_W(3)) bus ();

  shift_reg_engine #(
    .WIDTH (8),
    .AMT_W (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one command for a single accept edge; caller is then in cycle N+1.
  task automatic send(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] data);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_amount = amt;
    bus.cmd_data   = data;
    tick();
    bus.cmd_valid  = 1'b0;
  endtask

  // Counts cycles until done, bounded so a stuck FSM cannot hang the run.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      if (bus.busy === 1'b1) busy_cycles++;
      tick();
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    int bcyc;
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = OP_NOP;
    bus.cmd_amount = '0;
    bus.cmd_data   = '0;
    bus.serial_in  = 1'b0;
    bus.step_en    = 1'b1;
    #12;
    check("rst_data", 32'(bus.data_out), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_sout", 32'(bus.serial_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(bus.cmd_ready), 32'h1);

    // 1: LOAD completes at the accept edge with a one-cycle done
    send(OP_LOAD, 3'd0, 8'hA5);
    check("t1_data", 32'(bus.data_out), 32'hA5);
    check("t1_done", 32'(bus.done), 32'h1);
    check("t1_busy", 32'(bus.busy), 32'h0);
    tick();
    check("t1_done_drop", 32'(bus.done), 32'h0);

    // 2: SHL 3 of 0x81 with fill 1
    send(OP_LOAD, 3'd0, 8'h81);
    bus.serial_in = 1'b1;
    send(OP_SHL, 3'd3, 8'h00);
    check("t2_busy", 32'(bus.busy), 32'h1);
    check("t2_ready", 32'(bus.cmd_ready), 32'h0);
    wait_done(cyc, bcyc);
    check("t2_latency", 32'(cyc), 32'd3);
    check("t2_busy_cycles", 32'(bcyc), 32'd3);
    check("t2_data", 32'(bus.data_out), 32'h0F);
    check("t2_sout", 32'(bus.serial_out), 32'h0);
    check("t2_ready_done", 32'(bus.cmd_ready), 32'h1);
    bus.serial_in = 1'b0;

    // 3: ASR 7 saturates; then ROR 1 of 0x01
    send(OP_LOAD, 3'd0, 8'h80);
    send(OP_ASR, 3'd7, 8'h00);
    wait_done(cyc, bcyc);
    check("t3_asr_latency", 32'(cyc), 32'd7);
    check("t3_asr_data", 32'(bus.data_out), 32'hFF);
    send(OP_LOAD, 3'd0, 8'h01);
    send(OP_ROR, 3'd1, 8'h00);
    wait_done(cyc, bcyc);
    check("t3_ror_data", 32'(bus.data_out), 32'h80);
    check("t3_ror_sout", 32'(bus.serial_out), 32'h1);

    // 4: ROL 3 of 0x96 with a two-cycle stall and a command offered mid-shift
    send(OP_LOAD, 3'd0, 8'h96);
    send(OP_ROL, 3'd3, 8'h00);
    tick();
    check("t4_step1", 32'(bus.data_out), 32'h2D);
    bus.step_en    = 1'b0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = OP_LOAD;
    bus.cmd_data   = 8'h00;
    tick();
    tick();
    check("t4_stall_data", 32'(bus.data_out), 32'h2D);
    check("t4_stall_busy", 32'(bus.busy), 32'h1);
    bus.cmd_valid = 1'b0;
    bus.step_en   = 1'b1;
    wait_done(cyc, bcyc);
    check("t4_latency_after_stall", 32'(cyc), 32'd2);
    check("t4_data", 32'(bus.data_out), 32'hB4);
    check("t4_sout", 32'(bus.serial_out), 32'h0);

    // 5: amount 0 is an immediate no-op; then CLEAR
    send(OP_LOAD, 3'd0, 8'h3C);
    send(OP_SHR, 3'd0, 8'h00);
    check("t5_k0_done", 32'(bus.done), 32'h1);
    check("t5_k0_busy", 32'(bus.busy), 32'h0);
    check("t5_k0_data", 32'(bus.data_out), 32'h3C);
    send(OP_CLEAR, 3'd0, 8'h00);
    check("t5_clear", 32'(bus.data_out), 32'h00);
    check("t5_clear_done", 32'(bus.done), 32'h1);

    // Boundary: SHL 7 of 0xFF with fill 0 leaves only the original LSB
    send(OP_LOAD, 3'd0, 8'hFF);
    send(OP_SHL, 3'd7, 8'h00);
    wait_done(cyc, bcyc);
    check("b_shl7_data", 32'(bus.data_out), 32'h80);
    check("b_shl7_sout", 32'(bus.serial_out), 32'h1);

    // 6: reset during the second step of SHR 5
    send(OP_LOAD, 3'd0, 8'hF1);
    send(OP_SHR, 3'd5, 8'h00);
    tick();
    check("t6_step1_data", 32'(bus.data_out), 32'h78);
    check("t6_step1_sout", 32'(bus.serial_out), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_data", 32'(bus.data_out), 32'h00);
    check("t6_rst_sout", 32'(bus.serial_out), 32'h0);
    check("t6_rst_busy", 32'(bus.busy), 32'h0);
    check("t6_rst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_ready", 32'(bus.cmd_ready), 32'h1);
    check("t6_idle_data", 32'(bus.data_out), 32'h00);
    send(OP_LOAD, 3'd0, 8'h5A);
    check("t6_load", 32'(bus.data_out), 32'h5A);
    check("t6_load_done", 32'(bus.done), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
